sal_cmd_issue: RTL and testbench
================================

# sal_cmd_issue

Consumer end of the bank controller's scheduling interface. Takes the per-cycle grants (ACT/RD/WR/PRE/REF) plus their address and ID fields, encodes them onto registered DDR3 command/address pins, and generates the read-return and write-data enable windows at CL/CWL. It sits between the bank controller and the PHY/DFI boundary and is the only block that drives the DRAM command bus.

## Interface
- BA_WIDTH, 3, bank address width
- RA_WIDTH, 16, row address width
- CA_WIDTH, 10, column address width (at most 10)
- ADDR_WIDTH, 16, DRAM address pin width (at least max(RA_WIDTH, 13))
- ID_WIDTH, 4, request ID width
- LEN_WIDTH, 4, burst length field width
- LAT_WIDTH, 5, width of the CL/CWL inputs

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cl_i  in  LAT_WIDTH  read latency in clocks; legal 5..24; static outside reset
- cwl_i  in  LAT_WIDTH  write latency in clocks; legal 5..24; static outside reset
- act_gnt_i / rd_gnt_i / wr_gnt_i / pre_gnt_i / ref_gnt_i  in  1 each  command grants from the bank controller
- ba_i  in  BA_WIDTH  bank address
- ra_i  in  RA_WIDTH  row address; sampled with act_gnt_i only
- ca_i  in  CA_WIDTH  column address; sampled with rd_gnt_i or wr_gnt_i only
- id_i  in  ID_WIDTH  request ID; sampled with rd_gnt_i or wr_gnt_i only
- len_i  in  LEN_WIDTH  burst length field; sampled with rd_gnt_i or wr_gnt_i only
- cke_o  out  1  clock enable
- cs_n_o, ras_n_o, cas_n_o, we_n_o  out  1 each  DDR3 command pins
- ba_o  out  BA_WIDTH  bank address pins
- addr_o  out  ADDR_WIDTH  address pins
- rd_en_o  out  1  read data window; PHY captures a beat on every cycle this is high
- rd_id_o  out  ID_WIDTH  ID of the read that owns the current rd_en_o cycle
- rd_len_o  out  LEN_WIDTH  len of that read
- rd_last_o  out  1  last cycle of the current read window
- wr_en_o  out  1  write data window; the write data must be presented on every cycle this is high
- wr_id_o  out  ID_WIDTH  ID of the write that owns the current wr_en_o cycle
- wr_last_o  out  1  last cycle of the current write window
- err_o  out  1  sticky protocol error flag

## Operation
- All outputs are registered.
- Reset values: cke_o=0; cs_n_o, ras_n_o, cas_n_o and we_n_o =1; ba_o=0; addr_o=0; every rd_*/wr_* output =0; err_o=0.
- cke_o rises on the first clk edge after rst_n deasserts and then stays at 1.
- Command encoding (cs_n/ras_n/cas_n/we_n):
  - ACT = 0011, with addr = ra_i zero-extended.
  - RD = 0101 and WR = 0100. For both: addr[CA_WIDTH-1:0] = ca_i, addr[10] = 0 (no auto-precharge), addr[12] = 1 (BL8), all other address bits 0.
  - PRE = 0010, with addr[10] = 0 (single bank).
  - REF = 0001, with addr = 0.
  - With no grant, drive deselect: cs_n=1, other pins =1, ba_o and addr_o hold their last values.
- ba_o = ba_i for ACT, RD, WR and PRE; it holds its last value for REF.
- More than one grant high in the same cycle:
  - set err_o;
  - issue the highest-priority command only. Priority: REF, PRE, ACT, WR, RD.
- Each RD or WR is one BL8 burst and occupies a data window of 4 consecutive clocks.
- Read and write windows are each scheduled through a delay line of at least 28 entries holding {valid, id, len}.
  - Entries are inserted at the command's issue cycle and read out at the tap selected by cl_i or cwl_i.
  - A 2-bit beat counter stretches each entry to 4 cycles; last asserts on beat 3.
- Read and write windows are independent and may overlap each other.
- A new RD whose window would start while a previous read window is still active (spacing under 4 cycles) sets err_o. The new ID takes over from its first window cycle and the old window is truncated. WR follows the same rule.
- err_o clears only on reset.
- Reset mid-operation: all pending windows are discarded immediately and the pins return to their reset values asynchronously.

## Timing
- Grant sampled at edge T. The command appears on the pins during cycle T+1 for exactly one cycle.
- Read window: rd_en_o is high in cycles T+1+cl_i through T+4+cl_i inclusive; rd_last_o is high in T+4+cl_i.
- Write window: wr_en_o is high in cycles T+1+cwl_i through T+4+cwl_i; wr_last_o is high in T+4+cwl_i.
- Back-to-back commands at spacing 4 give a continuous rd_en_o (or wr_en_o); rd_id_o changes at the window boundary.
- Command throughput is one command per cycle.

## Test plan
- Reset release: hold rst_n low, then release -> cke_o=0 during reset and 1 one cycle after release; pins stay at deselect (1111), err_o=0.
- ACT ba=2 ra=0x1234 at T, then RD ca=0x3F id=5 at T+5, cl_i=11 -> ACT pins 0011 with addr 0x1234 in T+1; RD pins 0101 with addr 0x103F and ba 2 in T+6; rd_en_o high in T+17..T+20 with rd_id_o=5; rd_last_o in T+20.
- WR id=3 at T, cwl_i=8 -> pins 0100 in T+1; wr_en_o high in T+9..T+12; wr_last_o in T+12.
- RD id=1 at T and RD id=2 at T+4, cl_i=5 -> rd_en_o continuous T+6..T+13; id 1 in T+6..T+9 and id 2 in T+10..T+13; err_o stays 0.
- act_gnt_i and ref_gnt_i high together -> only REF (0001) issued; err_o=1 and remains 1 until reset.
- RD at T, cl_i=5, then rst_n pulsed low at T+3 -> rd_en_o never asserts; all outputs at reset values.

Source files
------------

// File: rtl/sal_cmd_issue_if.sv
// rtl/sal_cmd_issue_if.sv - scheduler grant/field bundle and DDR3 pin/window bundle
interface sal_cmd_issue_if #(
    parameter int BA_WIDTH   = 3,
    parameter int RA_WIDTH   = 16,
    parameter int CA_WIDTH   = 10,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  act_gnt_i;
    logic                  rd_gnt_i;
    logic                  wr_gnt_i;
    logic                  pre_gnt_i;
    logic                  ref_gnt_i;
    logic [BA_WIDTH-1:0]   ba_i;
    logic [RA_WIDTH-1:0]   ra_i;
    logic [CA_WIDTH-1:0]   ca_i;
    logic [ID_WIDTH-1:0]   id_i;
    logic [LEN_WIDTH-1:0]  len_i;

    logic                  cke_o;
    logic                  cs_n_o;
    logic                  ras_n_o;
    logic                  cas_n_o;
    logic                  we_n_o;
    logic [BA_WIDTH-1:0]   ba_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  rd_en_o;
    logic [ID_WIDTH-1:0]   rd_id_o;
    logic [LEN_WIDTH-1:0]  rd_len_o;
    logic                  rd_last_o;
    logic                  wr_en_o;
    logic [ID_WIDTH-1:0]   wr_id_o;
    logic                  wr_last_o;
    logic                  err_o;

    modport master (
        output act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i,
        output ba_i, ra_i, ca_i, id_i, len_i,
        input  cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o,
        input  rd_en_o, rd_id_o, rd_len_o, rd_last_o,
        input  wr_en_o, wr_id_o, wr_last_o, err_o
    );

    modport slave (
        input  act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i,
        input  ba_i, ra_i, ca_i, id_i, len_i,
        output cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o,
        output rd_en_o, rd_id_o, rd_len_o, rd_last_o,
        output wr_en_o, wr_id_o, wr_last_o, err_o
    );
endinterface

// File: rtl/sal_cmd_issue.sv
// rtl/sal_cmd_issue.sv - DDR3 command pin encoder with CL/CWL read/write data windows
module sal_cmd_issue #(
    parameter int BA_WIDTH   = 3,
    parameter int RA_WIDTH   = 16,
    parameter int CA_WIDTH   = 10,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int LAT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LAT_WIDTH-1:0] cl_i,
    input  logic [LAT_WIDTH-1:0] cwl_i,
    sal_cmd_issue_if.slave       bus
);
    localparam int DEPTH = 2 ** LAT_WIDTH;
    localparam int REW   = 1 + ID_WIDTH + LEN_WIDTH;
    localparam int WEW   = 1 + ID_WIDTH;

    localparam logic [3:0] CMD_NOP = 4'b1111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    logic [4:0]            gnts;
    logic                  multi_gnt;
    logic [3:0]            cmd_n;
    logic [BA_WIDTH-1:0]   ba_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [ADDR_WIDTH-1:0] act_addr;
    logic [ADDR_WIDTH-1:0] rw_addr;
    logic                  rd_ins;
    logic                  wr_ins;

    logic [REW-1:0]        rd_dl [DEPTH];
    logic [WEW-1:0]        wr_dl [DEPTH];
    logic [LAT_WIDTH-1:0]  rd_idx;
    logic [LAT_WIDTH-1:0]  wr_idx;
    logic [REW-1:0]        rd_tap;
    logic [WEW-1:0]        wr_tap;
    logic [1:0]            rd_beat;
    logic [1:0]            wr_beat;
    logic                  rd_ovl;
    logic                  wr_ovl;

    assign gnts      = {bus.ref_gnt_i, bus.pre_gnt_i, bus.act_gnt_i, bus.wr_gnt_i, bus.rd_gnt_i};
    assign multi_gnt = (gnts & (gnts - 5'd1)) != 5'd0;

    // Priority REF > PRE > ACT > WR > RD; losers are dropped and flagged via multi_gnt.
    always_comb begin
        cmd_n    = CMD_NOP;
        ba_n     = bus.ba_o;
        addr_n   = bus.addr_o;
        rd_ins   = 1'b0;
        wr_ins   = 1'b0;
        act_addr = '0;
        act_addr[RA_WIDTH-1:0] = bus.ra_i;
        rw_addr  = '0;
        rw_addr[CA_WIDTH-1:0]  = bus.ca_i;
        rw_addr[12]            = 1'b1;
        if (bus.ref_gnt_i) begin
            cmd_n  = CMD_REF;
            addr_n = '0;
        end else if (bus.pre_gnt_i) begin
            cmd_n  = CMD_PRE;
            ba_n   = bus.ba_i;
            addr_n = '0;
        end else if (bus.act_gnt_i) begin
            cmd_n  = CMD_ACT;
            ba_n   = bus.ba_i;
            addr_n = act_addr;
        end else if (bus.wr_gnt_i) begin
            cmd_n  = CMD_WR;
            ba_n   = bus.ba_i;
            addr_n = rw_addr;
            wr_ins = 1'b1;
        end else if (bus.rd_gnt_i) begin
            cmd_n  = CMD_RD;
            ba_n   = bus.ba_i;
            addr_n = rw_addr;
            rd_ins = 1'b1;
        end
    end

    // Entry written at the issue edge sits in slot k-1 just before edge k, hence tap = latency-1.
    assign rd_idx = cl_i - LAT_WIDTH'(1);
    assign wr_idx = cwl_i - LAT_WIDTH'(1);
    assign rd_tap = rd_dl[rd_idx];
    assign wr_tap = wr_dl[wr_idx];
    assign rd_ovl = rd_tap[REW-1] && bus.rd_en_o && (rd_beat != 2'd3);
    assign wr_ovl = wr_tap[WEW-1] && bus.wr_en_o && (wr_beat != 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_dl[i] <= '0;
                wr_dl[i] <= '0;
            end
        end else begin
            rd_dl[0] <= {rd_ins, bus.id_i, bus.len_i};
            wr_dl[0] <= {wr_ins, bus.id_i};
            for (int i = 1; i < DEPTH; i++) begin
                rd_dl[i] <= rd_dl[i-1];
                wr_dl[i] <= wr_dl[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cke_o <= 1'b0;
            {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= CMD_NOP;
            bus.ba_o   <= '0;
            bus.addr_o <= '0;
            bus.err_o  <= 1'b0;
        end else begin
            bus.cke_o <= 1'b1;
            {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= cmd_n;
            bus.ba_o   <= ba_n;
            bus.addr_o <= addr_n;
            bus.err_o  <= bus.err_o | multi_gnt | rd_ovl | wr_ovl;
        end
    end

    // A tap hit always restarts the window, truncating any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_en_o   <= 1'b0;
            bus.rd_id_o   <= '0;
            bus.rd_len_o  <= '0;
            bus.rd_last_o <= 1'b0;
            rd_beat       <= 2'd0;
        end else if (rd_tap[REW-1]) begin
            bus.rd_en_o   <= 1'b1;
            bus.rd_id_o   <= rd_tap[REW-2 -: ID_WIDTH];
            bus.rd_len_o  <= rd_tap[LEN_WIDTH-1:0];
            bus.rd_last_o <= 1'b0;
            rd_beat       <= 2'd0;
        end else if (bus.rd_en_o && rd_beat != 2'd3) begin
            bus.rd_last_o <= (rd_beat == 2'd2);
            rd_beat       <= rd_beat + 2'd1;
        end else begin
            bus.rd_en_o   <= 1'b0;
            bus.rd_id_o   <= '0;
            bus.rd_len_o  <= '0;
            bus.rd_last_o <= 1'b0;
            rd_beat       <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en_o   <= 1'b0;
            bus.wr_id_o   <= '0;
            bus.wr_last_o <= 1'b0;
            wr_beat       <= 2'd0;
        end else if (wr_tap[WEW-1]) begin
            bus.wr_en_o   <= 1'b1;
            bus.wr_id_o   <= wr_tap[ID_WIDTH-1:0];
            bus.wr_last_o <= 1'b0;
            wr_beat       <= 2'd0;
        end else if (bus.wr_en_o && wr_beat != 2'd3) begin
            bus.wr_last_o <= (wr_beat == 2'd2);
            wr_beat       <= wr_beat + 2'd1;
        end else begin
            bus.wr_en_o   <= 1'b0;
            bus.wr_id_o   <= '0;
            bus.wr_last_o <= 1'b0;
            wr_beat       <= 2'd0;
        end
    end
endmodule

// File: tb/tb_sal_cmd_issue.sv
// tb/tb_sal_cmd_issue.sv - randomized bench for sal_cmd_issue against a per-cycle expectation table
module tb_sal_cmd_issue;
    localparam int BA_W  = 3;
    localparam int RA_W  = 16;
    localparam int CA_W  = 10;
    localparam int AD_W  = 16;
    localparam int ID_W  = 4;
    localparam int LEN_W = 4;
    localparam int LAT_W = 5;
    localparam int NE    = 1024;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [LAT_W-1:0] cl    = 5'd5;
    logic [LAT_W-1:0] cwl   = 5'd5;

    sal_cmd_issue_if #(.BA_WIDTH(BA_W), .RA_WIDTH(RA_W), .CA_WIDTH(CA_W), .ADDR_WIDTH(AD_W),
                       .ID_WIDTH(ID_W), .LEN_WIDTH(LEN_W)) bus ();

    sal_cmd_issue #(.BA_WIDTH(BA_W), .RA_WIDTH(RA_W), .CA_WIDTH(CA_W), .ADDR_WIDTH(AD_W),
                    .ID_WIDTH(ID_W), .LEN_WIDTH(LEN_W), .LAT_WIDTH(LAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cl_i  (cl),
        .cwl_i (cwl),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] pins;
    assign pins = {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o};

    int n_checks = 0;
    int n_errors = 0;
    int e = 0;

    // Expected output values indexed by clock edge since the last reset release.
    logic [3:0]       x_cmd     [NE];
    logic [BA_W-1:0]  x_ba      [NE];
    logic [AD_W-1:0]  x_addr    [NE];
    logic [AD_W-1:0]  x_mask    [NE];
    logic             x_rd_en   [NE];
    logic             x_rd_last [NE];
    logic [ID_W-1:0]  x_rd_id   [NE];
    logic [LEN_W-1:0] x_rd_len  [NE];
    logic             x_wr_en   [NE];
    logic             x_wr_last [NE];
    logic [ID_W-1:0]  x_wr_id   [NE];
    logic [BA_W-1:0]  m_ba;
    logic [AD_W-1:0]  m_addr;
    logic [AD_W-1:0]  m_mask;
    int               err_due;
    int               last_rd;
    int               last_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            x_cmd[i] = 4'b1111; x_ba[i] = '0; x_addr[i] = '0; x_mask[i] = '1;
            x_rd_en[i] = 0; x_rd_last[i] = 0; x_rd_id[i] = '0; x_rd_len[i] = '0;
            x_wr_en[i] = 0; x_wr_last[i] = 0; x_wr_id[i] = '0;
        end
        m_ba = '0; m_addr = '0; m_mask = '1;
        err_due = 1 << 30; last_rd = -100; last_wr = -100; e = 0;
    endtask

    // A burst owns 4 data cycles starting at s; a later burst overwrites whatever it overlaps.
    task automatic model_window(input bit is_rd, input int s, input logic [ID_W-1:0] id,
                                input logic [LEN_W-1:0] len);
        if (is_rd && s < NE && x_rd_en[s] && s < err_due) err_due = s;
        if (!is_rd && s < NE && x_wr_en[s] && s < err_due) err_due = s;
        for (int k = 0; k < 4; k++) begin
            if (s + k < NE) begin
                if (is_rd) begin
                    x_rd_en[s+k] = 1; x_rd_id[s+k] = id; x_rd_len[s+k] = len; x_rd_last[s+k] = (k == 3);
                end else begin
                    x_wr_en[s+k] = 1; x_wr_id[s+k] = id; x_wr_last[s+k] = (k == 3);
                end
            end
        end
    endtask

    // g = {ref, pre, act, wr, rd}; n is the edge that samples the grant.
    task automatic model_issue(input int n, input logic [4:0] g, input logic [BA_W-1:0] ba,
                               input logic [RA_W-1:0] ra, input logic [CA_W-1:0] ca,
                               input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
        logic [3:0] cmd;
        if (n >= NE) return;
        if ($countones(g) > 1 && n < err_due) err_due = n;
        cmd = 4'b1111;
        if (g[4]) begin
            cmd = 4'b0001; m_addr = '0; m_mask = '1;
        end else if (g[3]) begin
            cmd = 4'b0010; m_ba = ba; m_addr = '0; m_mask = 16'h0400;
        end else if (g[2]) begin
            cmd = 4'b0011; m_ba = ba; m_addr = AD_W'(ra); m_mask = '1;
        end else if (g[1]) begin
            cmd = 4'b0100; m_ba = ba; m_addr = 16'h1000 | AD_W'(ca); m_mask = '1;
            model_window(1'b0, n + int'(cwl), id, '0);
        end else if (g[0]) begin
            cmd = 4'b0101; m_ba = ba; m_addr = 16'h1000 | AD_W'(ca); m_mask = '1;
            model_window(1'b1, n + int'(cl), id, len);
        end
        x_cmd[n] = cmd; x_ba[n] = m_ba; x_addr[n] = m_addr; x_mask[n] = m_mask;
    endtask

    task automatic check_edge();
        if (e >= NE) return;
        check("cke", 32'(bus.cke_o), 32'(e >= 1));
        check("pins", 32'(pins), 32'(x_cmd[e]));
        check("ba", 32'(bus.ba_o), 32'(x_ba[e]));
        check("addr", 32'(bus.addr_o & x_mask[e]), 32'(x_addr[e] & x_mask[e]));
        check("rd_en", 32'(bus.rd_en_o), 32'(x_rd_en[e]));
        check("rd_last", 32'(bus.rd_last_o), 32'(x_rd_last[e]));
        if (x_rd_en[e]) begin
            check("rd_id", 32'(bus.rd_id_o), 32'(x_rd_id[e]));
            check("rd_len", 32'(bus.rd_len_o), 32'(x_rd_len[e]));
        end
        check("wr_en", 32'(bus.wr_en_o), 32'(x_wr_en[e]));
        check("wr_last", 32'(bus.wr_last_o), 32'(x_wr_last[e]));
        if (x_wr_en[e]) check("wr_id", 32'(bus.wr_id_o), 32'(x_wr_id[e]));
        check("err", 32'(bus.err_o), 32'(e >= err_due));
    endtask

    task automatic step(input logic [4:0] g, input logic [BA_W-1:0] ba, input logic [RA_W-1:0] ra,
                        input logic [CA_W-1:0] ca, input logic [ID_W-1:0] id,
                        input logic [LEN_W-1:0] len);
        {bus.ref_gnt_i, bus.pre_gnt_i, bus.act_gnt_i, bus.wr_gnt_i, bus.rd_gnt_i} = g;
        bus.ba_i = ba; bus.ra_i = ra; bus.ca_i = ca; bus.id_i = id; bus.len_i = len;
        model_issue(e + 1, g, ba, ra, ca, id, len);
        @(posedge clk);
        e++;
        @(negedge clk);
        check_edge();
    endtask

    task automatic rstep(input logic [4:0] g);
        step(g, BA_W'($urandom), RA_W'($urandom), CA_W'($urandom), ID_W'($urandom), LEN_W'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rstep(5'b00000);
    endtask

    task automatic check_reset_values();
        check("rst_cke", 32'(bus.cke_o), 32'd0);
        check("rst_pins", 32'(pins), 32'hF);
        check("rst_ba", 32'(bus.ba_o), 32'd0);
        check("rst_addr", 32'(bus.addr_o), 32'd0);
        check("rst_rd", 32'({bus.rd_en_o, bus.rd_id_o, bus.rd_len_o, bus.rd_last_o}), 32'd0);
        check("rst_wr", 32'({bus.wr_en_o, bus.wr_id_o, bus.wr_last_o}), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
    endtask

    // Called just after a falling edge; asserts reset asynchronously and releases it two cycles later.
    task automatic do_reset(input logic [LAT_W-1:0] c, input logic [LAT_W-1:0] w);
        rst_n = 1'b0;
        cl = c; cwl = w;
        {bus.ref_gnt_i, bus.pre_gnt_i, bus.act_gnt_i, bus.wr_gnt_i, bus.rd_gnt_i} = '0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic legal_traffic(input int n);
        int k;
        logic [4:0] g;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 7);
            g = 5'b00000;
            case (k)
                0: if (e + 1 - last_rd >= 4) begin g = 5'b00001; last_rd = e + 1; end
                1: if (e + 1 - last_wr >= 4) begin g = 5'b00010; last_wr = e + 1; end
                2: g = 5'b00100;
                3: g = 5'b01000;
                4: g = 5'b10000;
                default: g = 5'b00000;
            endcase
            rstep(g);
        end
    endtask

    initial begin
        {bus.ref_gnt_i, bus.pre_gnt_i, bus.act_gnt_i, bus.wr_gnt_i, bus.rd_gnt_i} = '0;
        bus.ba_i = '0; bus.ra_i = '0; bus.ca_i = '0; bus.id_i = '0; bus.len_i = '0;
        @(negedge clk);

        do_reset(5'd11, 5'd8);
        idle(1);
        step(5'b00100, 3'd2, 16'h1234, '0, '0, '0);
        check("act_addr", 32'(bus.addr_o), 32'h1234);
        idle(4);
        step(5'b00001, 3'd2, '0, 10'h03F, 4'd5, 4'd7);
        check("rd_pins", 32'(pins), 32'h5);
        check("rd_addr", 32'(bus.addr_o), 32'h103F);
        idle(16);
        step(5'b00010, 3'd1, '0, 10'h155, 4'd3, 4'd0);
        idle(14);

        do_reset(5'd5, 5'd5);
        step(5'b00001, 3'd0, '0, 10'h010, 4'd1, 4'd2);
        idle(3);
        step(5'b00001, 3'd0, '0, 10'h020, 4'd2, 4'd3);
        idle(12);
        step(5'b10100, 3'd4, 16'hBEEF, '0, '0, '0);
        check("act_ref_pins", 32'(pins), 32'h1);
        idle(3);

        do_reset(5'd5, 5'd6);
        step(5'b00001, 3'd3, '0, 10'h2AA, 4'd9, 4'd4);
        idle(2);
        do_reset(5'd5, 5'd6);
        idle(12);

        for (int r = 0; r < 4; r++) begin
            do_reset(LAT_W'($urandom_range(5, 24)), LAT_W'($urandom_range(5, 24)));
            legal_traffic(120);
            for (int i = 0; i < 25; i++) rstep(5'($urandom_range(0, 31)));
            idle(32);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
